// File: rtl/semi_cpu_pkg.sv
// Shared types and constants for the instruction sequencer: FSM state
// encoding, opcode values, datapath widths and small counter helpers.
package semi_cpu_pkg;

    localparam int PC_W      = 8;
    localparam int RETIRED_W = 16;
    localparam int INSTR_W   = 32;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_HALT = 3'b001;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        WRITEBACK = 3'd4,
        HALT      = 3'd5
    } seq_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [RETIRED_W-1:0] sat_inc(input logic [RETIRED_W-1:0] value);
        if (value == {RETIRED_W{1'b1}}) begin
            sat_inc = value;
        end else begin
            sat_inc = value + {{(RETIRED_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // NOP and HALT leave the register file untouched; every other opcode writes.
    function automatic logic op_writes_back(input logic [2:0] opcode);
        op_writes_back = (opcode != OP_NOP) && (opcode != OP_HALT);
    endfunction

endpackage

// File: rtl/seq_counters.sv
// Program counter and retired-instruction counter for the sequencer.
// The PC wraps modulo 256; the retired count saturates at all-ones.
module seq_counters
    import semi_cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pc_inc,
    input  logic                 pc_clr,
    input  logic                 ret_inc,
    output logic [PC_W-1:0]      pc,
    output logic [RETIRED_W-1:0] retired
);

    logic [PC_W-1:0]      pc_r;
    logic [RETIRED_W-1:0] retired_r;

    // PC: cleared on restart, advanced after each writeback with natural wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= {PC_W{1'b0}};
        end else if (pc_clr) begin
            pc_r <= {PC_W{1'b0}};
        end else if (pc_inc) begin
            pc_r <= pc_r + {{(PC_W-1){1'b0}}, 1'b1};
        end else begin
            pc_r <= pc_r;
        end
    end

    // Retired count: one per completed instruction, held at the top value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_r <= {RETIRED_W{1'b0}};
        end else if (ret_inc) begin
            retired_r <= sat_inc(retired_r);
        end else begin
            retired_r <= retired_r;
        end
    end

    assign pc      = pc_r;
    assign retired = retired_r;

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches a word from instruction memory, then steps
// it through DECODE, EXECUTE and WRITEBACK, gating the decoder enable and the
// register-file write strobe. Opcode 001 stops the machine in HALT.
// Optional build macro INSTR_SEQ_TIMEOUT_EN adds a 16-cycle fetch timeout
// that raises `fault` and parks the sequencer in HALT.
module instr_sequencer
    import semi_cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 imem_req,
    output logic [PC_W-1:0]      imem_addr,
    input  logic                 imem_ack,
    input  logic [INSTR_W-1:0]   imem_rdata,
    output logic [INSTR_W-1:0]   instr_out,
    output logic                 dec_control,
    output logic                 wb_en,
    output logic [PC_W-1:0]      pc,
    output logic                 busy,
    output logic                 halted,
    output logic [RETIRED_W-1:0] retired
`ifdef INSTR_SEQ_TIMEOUT_EN
    ,
    output logic                 fault
`endif
);

    seq_state_t           state_r;
    seq_state_t           state_s;
    logic [INSTR_W-1:0]   instr_r;
    logic [2:0]           opcode_s;
    logic                 latch_s;
    logic                 pc_inc_s;
    logic                 pc_clr_s;
    logic                 ret_inc_s;
    logic                 imem_req_r;
    logic                 dec_control_r;
    logic                 wb_en_r;
    logic                 busy_r;
    logic                 halted_r;
    logic [PC_W-1:0]      pc_s;

`ifdef INSTR_SEQ_TIMEOUT_EN
    logic [3:0]           wait_cnt_r;
    logic                 timeout_s;
    logic                 fault_r;
`endif

    assign opcode_s = instr_r[31:29];

    // Next-state logic and counter strobes
    always_comb begin
        state_s   = state_r;
        latch_s   = 1'b0;
        pc_inc_s  = 1'b0;
        pc_clr_s  = 1'b0;
        ret_inc_s = 1'b0;
`ifdef INSTR_SEQ_TIMEOUT_EN
        timeout_s = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = FETCH;
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                if (imem_ack) begin
                    latch_s = 1'b1;
                    state_s = DECODE;
`ifdef INSTR_SEQ_TIMEOUT_EN
                end else if (wait_cnt_r == 4'hF) begin
                    timeout_s = 1'b1;
                    state_s   = HALT;
`endif
                end else begin
                    state_s = FETCH;
                end
            end
            DECODE: begin
                if (opcode_s == OP_HALT) begin
                    // HALT retires without a writeback and without moving the PC
                    ret_inc_s = 1'b1;
                    state_s   = HALT;
                end else begin
                    state_s = EXECUTE;
                end
            end
            EXECUTE: begin
                state_s = WRITEBACK;
            end
            WRITEBACK: begin
                pc_inc_s  = 1'b1;
                ret_inc_s = 1'b1;
                state_s   = FETCH;
            end
            HALT: begin
                if (start) begin
                    pc_clr_s = 1'b1;
                    state_s  = FETCH;
                end else begin
                    state_s = HALT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register plus outputs registered from the next state, so each
    // output is valid in the same cycle as the state it describes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            imem_req_r    <= 1'b0;
            dec_control_r <= 1'b0;
            wb_en_r       <= 1'b0;
            busy_r        <= 1'b0;
            halted_r      <= 1'b0;
        end else begin
            state_r       <= state_s;
            imem_req_r    <= (state_s == FETCH);
            dec_control_r <= (state_s == DECODE) || (state_s == EXECUTE) ||
                             (state_s == WRITEBACK);
            // Entering WRITEBACK means we are in EXECUTE, so instr_r is stable
            wb_en_r       <= (state_s == WRITEBACK) && op_writes_back(opcode_s);
            busy_r        <= (state_s != IDLE) && (state_s != HALT);
            halted_r      <= (state_s == HALT);
        end
    end

    // Instruction latch, loaded only by an ack taken in FETCH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_r <= {INSTR_W{1'b0}};
        end else if (latch_s) begin
            instr_r <= imem_rdata;
        end else begin
            instr_r <= instr_r;
        end
    end

`ifdef INSTR_SEQ_TIMEOUT_EN
    // Fetch wait counter: counts unacknowledged FETCH cycles, zero elsewhere
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= 4'd0;
        end else if ((state_r == FETCH) && !imem_ack) begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
        end else begin
            wait_cnt_r <= 4'd0;
        end
    end

    // Fault flag: set by a fetch timeout, cleared by a restart from HALT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_r <= 1'b0;
        end else if (timeout_s) begin
            fault_r <= 1'b1;
        end else if (pc_clr_s) begin
            fault_r <= 1'b0;
        end else begin
            fault_r <= fault_r;
        end
    end

    assign fault = fault_r;
`endif

    seq_counters u_counters (
        .clk     (clk),
        .rst_n   (rst_n),
        .pc_inc  (pc_inc_s),
        .pc_clr  (pc_clr_s),
        .ret_inc (ret_inc_s),
        .pc      (pc_s),
        .retired (retired)
    );

    assign imem_req    = imem_req_r;
    assign imem_addr   = pc_s;
    assign pc          = pc_s;
    assign instr_out   = instr_r;
    assign dec_control = dec_control_r;
    assign wb_en       = wb_en_r;
    assign busy        = busy_r;
    assign halted      = halted_r;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer. A transaction-level model walks
// each instruction through its fetch/decode/execute/writeback schedule and
// predicts every output in every cycle. Define INSTR_SEQ_TIMEOUT_EN to also
// exercise the fetch timeout.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic        dec_control;
    logic        wb_en;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;
    logic [15:0] retired;
`ifdef INSTR_SEQ_TIMEOUT_EN
    logic        fault;
`endif

    // Reference model state
    logic [31:0] mem [256];
    int          m_pc;
    int          m_ret;
    logic [31:0] m_instr;
    bit          m_fault;
    int          checks;
    int          errors;

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_out   (instr_out),
        .dec_control (dec_control),
        .wb_en       (wb_en),
        .pc          (pc),
        .busy        (busy),
        .halted      (halted),
        .retired     (retired)
`ifdef INSTR_SEQ_TIMEOUT_EN
        ,
        .fault       (fault)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit coin();
        return ($urandom & 32'd1) != 32'd0;
    endfunction

    function automatic int sat_next(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    // Random opcode other than HALT
    function automatic logic [31:0] rand_word_nohalt();
        logic [31:0] w;
        logic [2:0]  op;
        w  = $urandom;
        op = 3'($urandom_range(0, 6));
        if (op != 3'd0) op = op + 3'd1;
        w[31:29] = op;
        return w;
    endfunction

    // One clock cycle: check this cycle's outputs, then drive its inputs
    task automatic cycle(input bit e_req, input bit e_dec, input bit e_wb, input bit e_busy,
                         input bit e_halt, input bit ack, input logic [31:0] rd, input bit st);
        @(negedge clk);
        check_eq("imem_req",    32'(imem_req),    32'(e_req));
        check_eq("imem_addr",   32'(imem_addr),   32'(m_pc));
        check_eq("pc",          32'(pc),          32'(m_pc));
        check_eq("dec_control", 32'(dec_control), 32'(e_dec));
        check_eq("wb_en",       32'(wb_en),       32'(e_wb));
        check_eq("busy",        32'(busy),        32'(e_busy));
        check_eq("halted",      32'(halted),      32'(e_halt));
        check_eq("instr_out",   instr_out,        m_instr);
        check_eq("retired",     32'(retired),     32'(m_ret));
`ifdef INSTR_SEQ_TIMEOUT_EN
        check_eq("fault",       32'(fault),       32'(m_fault));
`endif
        imem_ack   = ack;
        imem_rdata = rd;
        start      = st;
    endtask

    task automatic check_all_zero(input string when);
        check_eq({when, "_imem_req"}, 32'(imem_req),    32'd0);
        check_eq({when, "_dec"},      32'(dec_control), 32'd0);
        check_eq({when, "_wb_en"},    32'(wb_en),       32'd0);
        check_eq({when, "_busy"},     32'(busy),        32'd0);
        check_eq({when, "_halted"},   32'(halted),      32'd0);
        check_eq({when, "_pc"},       32'(pc),          32'd0);
        check_eq({when, "_instr"},    instr_out,        32'd0);
        check_eq({when, "_retired"},  32'(retired),     32'd0);
`ifdef INSTR_SEQ_TIMEOUT_EN
        check_eq({when, "_fault"},    32'(fault),       32'd0);
`endif
    endtask

    // Assert reset (optionally at the next negedge), check it takes effect at once
    task automatic do_reset(input bit at_negedge);
        if (at_negedge) begin
            @(negedge clk);
            check_eq("pre_rst_pc",      32'(pc),      32'(m_pc));
            check_eq("pre_rst_retired", 32'(retired), 32'(m_ret));
        end
        rst_n      = 1'b0;
        start      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        #1;
        check_all_zero("rst_async");
        m_pc    = 0;
        m_ret   = 0;
        m_instr = 32'd0;
        m_fault = 1'b0;
        @(negedge clk);
        check_all_zero("rst_held");
        rst_n = 1'b1;
    endtask

    // Run one instruction from FETCH; ack arrives after `delay` wait cycles
    task automatic exec_instr(input int delay, output bit was_halt);
        logic [2:0] op;
        for (int w = 0; w <= delay; w++) begin
            if (w == delay) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, mem[m_pc], coin());
            else            cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, $urandom, coin());
        end
        m_instr = mem[m_pc];
        op      = m_instr[31:29];
        // stray acks and starts after FETCH must be ignored
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, coin(), $urandom, coin());
        if (op == 3'b001) begin
            m_ret    = sat_next(m_ret);
            was_halt = 1'b1;
        end else begin
            cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, coin(), $urandom, coin());
            cycle(1'b0, 1'b1, op >= 3'd2, 1'b1, 1'b0, coin(), $urandom, coin());
            m_pc     = (m_pc + 1) % 256;
            m_ret    = sat_next(m_ret);
            was_halt = 1'b0;
        end
    endtask

    task automatic start_from_idle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    endtask

    task automatic restart_from_halt();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        m_pc    = 0;
        m_fault = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit h;
        checks = 0; errors = 0;
        rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
        m_pc = 0; m_ret = 0; m_instr = 32'd0; m_fault = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;

        do_reset(1'b0);
        // idle with stray acks: nothing may move
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, coin(), $urandom, 1'b0);

        // opcode 010 at address 0, zero-wait memory
        mem[0] = {3'b010, 29'($urandom)};
        start_from_idle();
        exec_instr(0, h);
        do_reset(1'b1);

        // opcode 000: four cycles, no write strobe
        mem[0] = {3'b000, 29'($urandom)};
        start_from_idle();
        exec_instr(0, h);
        do_reset(1'b1);

        // three 011 then HALT at address 3, restart, then a 5-cycle-late ack
        for (int i = 0; i < 3; i++) mem[i] = {3'b011, 29'($urandom)};
        mem[3] = {3'b001, 29'($urandom)};
        start_from_idle();
        for (int i = 0; i < 4; i++) exec_instr($urandom_range(0, 2), h);
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, coin(), $urandom, 1'b0);
        restart_from_halt();
        exec_instr(1, h);
        mem[1] = {3'b100, 29'($urandom)};
        exec_instr(5, h);
        do_reset(1'b1);

        // random non-halt program across the whole address space: PC wraps
        for (int i = 0; i < 255; i++) mem[i] = rand_word_nohalt();
        mem[255] = {3'b110, 29'($urandom)};
        start_from_idle();
        for (int i = 0; i < 257; i++) exec_instr($urandom_range(0, 3), h);
        do_reset(1'b1);

        // reset during EXECUTE abandons the instruction
        mem[0] = {3'b101, 29'($urandom)};
        start_from_idle();
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, mem[0], 1'b0);
        m_instr = mem[0];
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        do_reset(1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

        // random program with halts and restarts
        for (int i = 0; i < 256; i++) begin
            mem[i] = rand_word_nohalt();
            if ($urandom_range(0, 5) == 0) mem[i][31:29] = 3'b001;
        end
        start_from_idle();
        for (int n = 0; n < 80; n++) begin
            exec_instr($urandom_range(0, 3), h);
            if (h) begin
                repeat ($urandom_range(1, 3))
                    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, coin(), $urandom, 1'b0);
                restart_from_halt();
            end
        end
        do_reset(1'b1);

`ifdef INSTR_SEQ_TIMEOUT_EN
        // no ack: fault and halted exactly 16 cycles after FETCH entry
        mem[0] = {3'b010, 29'($urandom)};
        start_from_idle();
        for (int w = 0; w < 16; w++)
            cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, $urandom, coin());
        m_fault = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        restart_from_halt();
        exec_instr(2, h);
        do_reset(1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: `clk input 1`, rising-edge clock for all state.
REQ-002 `rst_n input 1`: asynchronous active-low reset.
REQ-003 `start input 1`: run request, sampled in IDLE and HALT.
REQ-004 `imem_req output 1`: instruction fetch request, held high until acknowledged.
REQ-005 `imem_addr output 8`: fetch address, equal to the PC.
REQ-006 `imem_ack input 1`: fetch acknowledge; `imem_rdata` is valid in the same cycle.
REQ-007 `imem_rdata input 32`: fetched instruction word.
REQ-008 `instr_out output 32`: latched instruction fed to the decoder.
REQ-009 `dec_control output 1`: decoder enable; the decoder outputs are zero when this is low.
REQ-010 `wb_en output 1`: register-file write strobe, gated by the sequencer.
REQ-011 `pc output 8`: current program counter.
REQ-012 `busy output 1`: high in every state except IDLE and HALT.
REQ-013 `halted output 1`: high in HALT.
REQ-014 `retired output 16`: count of completed instructions.
REQ-015 `fault output 1`: fetch-timeout flag; exists only under the macro in REQ-030.

Function
REQ-016 The FSM SHALL have the states IDLE, FETCH, DECODE, EXECUTE, WRITEBACK and HALT.
REQ-017 IDLE: when `start`=1, the FSM SHALL go to FETCH on the next edge with the PC unchanged (0 after reset).
REQ-018 FETCH: `imem_req`=1 and `imem_addr`=`pc`.
  - When `imem_ack`=1, `imem_rdata` SHALL be latched into `instr_out` and the FSM SHALL go to DECODE.
  - `imem_req` SHALL drop in the cycle after the ack.
REQ-019 DECODE: `dec_control`=1, with `opcode`=`instr_out[31:29]`.
  - Opcode 001 (HALT) SHALL go to HALT without a writeback, with the PC unchanged and `retired` incremented.
  - Any other opcode SHALL go to EXECUTE.
REQ-020 EXECUTE: `dec_control`=1 for exactly one cycle, then the FSM SHALL go to WRITEBACK.
REQ-021 WRITEBACK: `dec_control`=1.
  - `wb_en`=1 only if the opcode is not 000 or 001.
  - PC SHALL become PC+1 modulo 256, so 255 wraps to 0.
  - `retired` SHALL be incremented, saturating at 16'hFFFF.
  - The FSM SHALL then go to FETCH.
REQ-022 `wb_en` SHALL never be high outside WRITEBACK.
REQ-023 `dec_control` SHALL be 0 in IDLE, FETCH and HALT.
REQ-024 Latency SHALL be 4 cycles per non-halt instruction with a zero-wait ack: FETCH, DECODE, EXECUTE, WRITEBACK.
REQ-025 HALT: when `start`=1, the block SHALL clear PC to 0, keep `retired`, and go to FETCH.
REQ-026 `start` SHALL be ignored while `busy`=1.
REQ-027 An `imem_ack` received outside FETCH SHALL be ignored.

Reset
REQ-028 When `rst_n`=0, the block SHALL immediately enter IDLE with all of the following at 0: `pc`, `instr_out`, `retired`, `imem_req`, `dec_control`, `wb_en`, `halted`, `busy`, `fault`.
REQ-029 A reset asserted mid-instruction SHALL abandon it with no writeback and no count; `imem_req` SHALL drop asynchronously.

Configuration
REQ-030 With `INSTR_SEQ_TIMEOUT_EN` defined, a 4-bit wait counter SHALL run in FETCH.
  - The counter SHALL clear on entering FETCH.
  - If 16 cycles pass without `imem_ack`, the block SHALL set `fault`=1, drop `imem_req` and go to HALT.
  - `fault` SHALL clear only on reset or on restart from HALT.
  - Without the macro, FETCH SHALL wait indefinitely, and there SHALL be no `fault` port and no counter.

Structure
REQ-031 Package `semi_cpu_pkg` SHALL hold:
  - the FSM state enum;
  - the opcode constants OP_NOP=000 and OP_HALT=001;
  - PC_W=8 and RETIRED_W=16.
REQ-032 The block SHALL be a single module; the PC/retired counters MAY be split into sub-module `seq_counters`. It has no other sub-modules.

Verification
REQ-033 Reset, then `start` with a zero-wait memory holding opcode 010 at address 0: `imem_req` at cycle 1; `wb_en` for one cycle at cycle 4; `pc`=1; `retired`=1.
REQ-034 Opcode 000 at address 0: the instruction completes in 4 cycles with `wb_en` never high; `pc`=1.
REQ-035 Opcode 001 at address 3 after three 011 instructions: HALT entered; `halted`=1; `pc`=3; `retired`=4; a later `start` restarts the fetch at address 0.
REQ-036 Ack delayed by 5 cycles: `imem_req` stays high for 6 cycles, and `instr_out` equals `rdata` in the ack cycle.
REQ-037 PC=255 with opcode 110: after WRITEBACK, `pc`=0. A separate check: `rst_n` pulsed during EXECUTE gives `wb_en`=0 and all outputs zero.
REQ-038 Under `INSTR_SEQ_TIMEOUT_EN`, with no ack: `fault`=1 and `halted`=1 exactly 16 cycles after FETCH entry.
